// File: rtl/wb_pipe_stage_pkg.sv
// Shared WB control layout, register-zero constant and default widths
// for the write-back pipeline.
package wb_pipe_stage_pkg;

  localparam int WB_REGWRITE    = 0;
  localparam int WB_MEMTOREG    = 1;
  localparam int REG_ZERO       = 0;
  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;

  // Packed so that bit 0 is RegWrite and bit 1 is MemtoReg, matching WB_i.
  typedef struct packed {
    logic memToReg;
    logic regWrite;
  } wbCtrl_t;

endpackage

// File: rtl/wb_pipe_stage_reg.sv
// One write-back pipeline stage: valid bit, WB control, load/ALU data and
// destination address. A bubble clears valid and WB but still loads data.
module wb_stage_reg
  import wb_pipe_stage_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall,
  input  logic              bubble,
  input  logic              validIn,
  input  logic [1:0]        wbIn,
  input  logic [DATA_W-1:0] memDataIn,
  input  logic [DATA_W-1:0] regDataIn,
  input  logic [ADDR_W-1:0] regAddrIn,
  output logic              validOut,
  output logic [1:0]        wbOut,
  output logic [DATA_W-1:0] memDataOut,
  output logic [DATA_W-1:0] regDataOut,
  output logic [ADDR_W-1:0] regAddrOut
);

  wbCtrl_t wbNext;

  always_comb begin
    wbNext = bubble ? '0 : wbCtrl_t'(wbIn);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      validOut   <= 1'b0;
      wbOut      <= '0;
      memDataOut <= '0;
      regDataOut <= '0;
      regAddrOut <= '0;
    end else if (!stall) begin
      validOut   <= validIn & ~bubble;
      wbOut      <= wbNext;
      memDataOut <= memDataIn;
      regDataOut <= regDataIn;
      regAddrOut <= regAddrIn;
    end
  end

endmodule

// File: rtl/wb_pipe_stage.sv
// DEPTH-deep MEM/WB pipeline with bubbles, resolved write-back data and a
// youngest-first forwarding lookup. WB_PERF_CNT_EN adds stall/retire counters.
module wb_pipe_stage
  import wb_pipe_stage_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DEPTH  = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              Stall_i,
  input  logic              Flush_i,
  input  logic              Valid_i,
  input  logic [1:0]        WB_i,
  input  logic [DATA_W-1:0] MemData_i,
  input  logic [DATA_W-1:0] RegData_i,
  input  logic [ADDR_W-1:0] RegAddr_i,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic [DATA_W-1:0] MemData_o,
  output logic [DATA_W-1:0] RegData_o,
  output logic [ADDR_W-1:0] RegAddr_o,
  output logic [DATA_W-1:0] WBData_o,
  input  logic [ADDR_W-1:0] FwdAddr_i,
  output logic              FwdHit_o,
`ifdef WB_PERF_CNT_EN
  output logic [31:0]       StallCnt_o,
  output logic [31:0]       RetireCnt_o,
`endif
  output logic [DATA_W-1:0] FwdData_o
);

  logic [DEPTH-1:0]             stValid;
  logic [DEPTH-1:0][1:0]        stWb;
  logic [DEPTH-1:0][DATA_W-1:0] stMem;
  logic [DEPTH-1:0][DATA_W-1:0] stReg;
  logic [DEPTH-1:0][ADDR_W-1:0] stAddr;

  for (genvar k = 0; k < DEPTH; k++) begin : gStage
    logic              inValid;
    logic              inBubble;
    logic [1:0]        inWb;
    logic [DATA_W-1:0] inMem;
    logic [DATA_W-1:0] inReg;
    logic [ADDR_W-1:0] inAddr;

    if (k == 0) begin : gHead
      // An invalid incoming entry is handled exactly like a flush.
      assign inValid  = Valid_i;
      assign inBubble = Flush_i | ~Valid_i;
      assign inWb     = WB_i;
      assign inMem    = MemData_i;
      assign inReg    = RegData_i;
      assign inAddr   = RegAddr_i;
    end else begin : gBody
      assign inValid  = stValid[k-1];
      assign inBubble = 1'b0;
      assign inWb     = stWb[k-1];
      assign inMem    = stMem[k-1];
      assign inReg    = stReg[k-1];
      assign inAddr   = stAddr[k-1];
    end

    wb_stage_reg #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) uStage (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .stall     (Stall_i),
      .bubble    (inBubble),
      .validIn   (inValid),
      .wbIn      (inWb),
      .memDataIn (inMem),
      .regDataIn (inReg),
      .regAddrIn (inAddr),
      .validOut  (stValid[k]),
      .wbOut     (stWb[k]),
      .memDataOut(stMem[k]),
      .regDataOut(stReg[k]),
      .regAddrOut(stAddr[k])
    );
  end

  wbCtrl_t lastWb;

  assign lastWb     = wbCtrl_t'(stWb[DEPTH-1]);
  assign RegWrite_o = stValid[DEPTH-1] & lastWb.regWrite;
  assign MemtoReg_o = lastWb.memToReg;
  assign MemData_o  = stMem[DEPTH-1];
  assign RegData_o  = stReg[DEPTH-1];
  assign RegAddr_o  = stAddr[DEPTH-1];
  assign WBData_o   = MemtoReg_o ? MemData_o : RegData_o;

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    FwdHit_o  = 1'b0;
    FwdData_o = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (stValid[k] && stWb[k][WB_REGWRITE] && (stAddr[k] == FwdAddr_i) &&
          (stAddr[k] != ADDR_W'(REG_ZERO))) begin
        FwdHit_o  = 1'b1;
        FwdData_o = stWb[k][WB_MEMTOREG] ? stMem[k] : stReg[k];
      end
    end
  end

`ifdef WB_PERF_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      StallCnt_o  <= '0;
      RetireCnt_o <= '0;
    end else begin
      if (Stall_i) StallCnt_o <= StallCnt_o + 32'd1;
      if (RegWrite_o && !Stall_i) RetireCnt_o <= RetireCnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/wb_pipe_stage.md
Name: wb_pipe_stage

Overview:
- Parametrised successor to the single-stage MEM/WB latch: a DEPTH-deep write-back pipeline carrying WB control, memory data, ALU data and destination register.
- Adds a per-stage valid bit, flush/bubble insertion, a resolved write-back result, and a forwarding lookup across all in-flight stages.
- Sits between the MEM stage and the register file.
- DEPTH>1 serves multi-cycle memory or extended write-back latency.

Parameters:
- DATA_W, 32, width of memory and ALU data
- ADDR_W, 5, register address width
- DEPTH, 1, number of pipeline stages (1..8)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-high reset
- Stall_i  in  1  hold every stage unchanged
- Flush_i  in  1  insert a bubble into stage 0 this cycle
- Valid_i  in  1  incoming entry is a real instruction
- WB_i  in  2  [0]=RegWrite, [1]=MemtoReg
- MemData_i  in  DATA_W  load data
- RegData_i  in  DATA_W  ALU result
- RegAddr_i  in  ADDR_W  destination register
- RegWrite_o  out  1  last stage RegWrite, gated by valid
- MemtoReg_o  out  1  last stage MemtoReg
- MemData_o  out  DATA_W  last stage load data
- RegData_o  out  DATA_W  last stage ALU data
- RegAddr_o  out  ADDR_W  last stage destination
- WBData_o  out  DATA_W  MemtoReg ? MemData_o : RegData_o
- FwdAddr_i  in  ADDR_W  forwarding query address
- FwdHit_o  out  1  some in-flight valid stage writes FwdAddr_i
- FwdData_o  out  DATA_W  resolved data of the youngest matching stage

Behaviour:
- The clock domain is clk_i only. rst_i is asynchronous and active-high.
- Reset: all stage valid bits, control bits, data and addresses go to 0. All outputs read 0 while rst_i is high and after it deasserts.
- Stage 0 loads from the inputs. Stage k loads from stage k-1. Outputs come from stage DEPTH-1.
- Latency: exactly DEPTH rising edges from input to outputs.
- Stall_i=1: no stage changes, including valid bits. Outputs are stable.
- Flush_i=1 and Stall_i=0: stage 0 loads valid=0 and WB=0. Data fields load normally (don't-care). Older stages advance.
- Flush_i=1 and Stall_i=1: stall wins, nothing changes. Upstream control re-asserts the flush after the stall ends.
- Valid_i=0 is treated as a bubble, identical to a flush.
- RegWrite_o = stage valid AND stored RegWrite. A bubble never reaches the register file.
- WBData_o: combinational mux of the last stage, 0 on reset.
- Forwarding lookup (combinational, same-cycle):
  - A stage matches when valid, RegWrite=1, RegAddr==FwdAddr_i and RegAddr!=0.
  - With several matches, the lowest-index (youngest) stage wins.
  - FwdData_o is that stage's MemtoReg-resolved data. It is 0 when FwdHit_o=0.
  - The query never matches on register 0.
- The stall does not affect the lookup; it reflects current stage contents.
- Reset mid-operation discards every in-flight entry immediately; no retirement occurs.

Optional Feature:
- WB_PERF_CNT_EN defined: adds outputs StallCnt_o [31:0] and RetireCnt_o [31:0].
  - StallCnt_o increments every cycle with Stall_i=1.
  - RetireCnt_o increments every cycle where RegWrite_o=1 and Stall_i=0.
  - Both wrap at 2^32 and reset to 0 on rst_i.
- Undefined: the counters and ports are absent. All other behaviour is identical.

Decomposition:
- Shared package:
  - WB bit indices (WB_REGWRITE=0, WB_MEMTOREG=1)
  - the WB control struct/typedef
  - register-zero constant
  - default DATA_W/ADDR_W
- Sub-module wb_stage_reg: one stage holding valid, WB, two data words and address, with stall/bubble load. Instantiate it DEPTH times via generate.
- Forwarding priority search stays in the top.

Test Plan:
- Reset: assert rst_i asynchronously between edges -> all outputs 0 without waiting for a clock edge; FwdHit_o=0.
- Basic flow, DEPTH=3: WB=01, RegData_i=0x1234, RegAddr_i=5 at edge 0 -> RegWrite_o=1, WBData_o=0x1234, RegAddr_o=5 exactly after edge 3.
- Stall: hold Stall_i=1 for 2 cycles with a MemtoReg entry (MemData_i=0xDEAD) in stage 1 -> outputs unchanged for 2 cycles; entry retires 2 cycles late with WBData_o=0xDEAD.
- Flush vs stall: Flush_i=1 with Stall_i=1 -> no change. Next cycle Flush_i=1, Stall_i=0 -> that entry retires with RegWrite_o=0.
- Forwarding priority: stage 0 writes r7=0x22, stage 2 writes r7=0x11, FwdAddr_i=7 -> FwdHit_o=1, FwdData_o=0x22. FwdAddr_i=0 with r0 writes in flight -> FwdHit_o=0.
- WB_PERF_CNT_EN: 3 stall cycles and 4 retired writes -> StallCnt_o=3, RetireCnt_o=4. Then rst_i -> both 0.
